// File: rtl/acc_conditioner_if.sv
// rtl/acc_conditioner_if.sv - sample and conditioned-acceleration bundle between I2C driver, conditioner and estimator
interface acc_conditioner_if;
    logic        end_flag;
    logic [7:0]  rx_hi;
    logic [7:0]  rx_lo;
    logic        recal;
    logic [15:0] acc_out;
    logic        acc_valid;
    logic        calib_done;

    modport master (
        output end_flag, rx_hi, rx_lo, recal,
        input  acc_out, acc_valid, calib_done
    );

    modport slave (
        input  end_flag, rx_hi, rx_lo, recal,
        output acc_out, acc_valid, calib_done
    );
endinterface

// File: rtl/acc_conditioner.sv
// rtl/acc_conditioner.sv - accelerometer capture, offset calibration and saturating correction; ACC_LPF_EN adds a 4-tap average
module acc_conditioner #(
    parameter int CAL_LOG2    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    acc_conditioner_if.slave bus
);
    localparam int SUM_W = 16 + CAL_LOG2;

    typedef enum logic {ST_CAL, ST_RUN} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_q;
    logic                     edge_det;
    logic                     take;
    logic signed [15:0]       raw_q;
    logic                     raw_vld;
    logic signed [15:0]       offset_q;
    logic signed [SUM_W-1:0]  sum_q;
    logic signed [SUM_W-1:0]  sum_next;
    logic [CAL_LOG2-1:0]      cnt_q;
    logic signed [15:0]       offset_next;
    logic [16:0]              diff;
    logic signed [15:0]       sat;

    always_comb begin
        edge_det    = sync_q[SYNC_STAGES-1] & ~prev_q;
        // A sample colliding with recal is dropped before it enters the pipeline.
        take        = edge_det & ~bus.recal;
        sum_next    = sum_q + $signed({{CAL_LOG2{raw_q[15]}}, raw_q});
        offset_next = 16'(sum_next >>> CAL_LOG2);
        diff        = {raw_q[15], raw_q} - {offset_q[15], offset_q};
        if (diff[16] != diff[15]) begin
            sat = diff[16] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            sat = diff[15:0];
        end
    end

`ifdef ACC_LPF_EN
    logic signed [15:0] tap_q [4];
    logic               lpf_vld;
    logic signed [17:0] lpf_sum;
    logic signed [15:0] lpf_avg;

    always_comb begin
        lpf_sum = $signed({{2{tap_q[0][15]}}, tap_q[0]}) + $signed({{2{tap_q[1][15]}}, tap_q[1]})
                + $signed({{2{tap_q[2][15]}}, tap_q[2]}) + $signed({{2{tap_q[3][15]}}, tap_q[3]});
        lpf_avg = 16'(lpf_sum >>> 2);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_CAL;
            sync_q         <= '0;
            prev_q         <= 1'b0;
            raw_q          <= '0;
            raw_vld        <= 1'b0;
            sum_q          <= '0;
            cnt_q          <= '0;
            offset_q       <= '0;
            bus.acc_out    <= '0;
            bus.acc_valid  <= 1'b0;
            bus.calib_done <= 1'b0;
`ifdef ACC_LPF_EN
            for (int i = 0; i < 4; i++) tap_q[i] <= '0;
            lpf_vld        <= 1'b0;
`endif
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.end_flag};
            prev_q        <= sync_q[SYNC_STAGES-1];
            raw_vld       <= take;
            bus.acc_valid <= 1'b0;
            if (take) begin
                raw_q <= {bus.rx_hi, bus.rx_lo};
            end
`ifdef ACC_LPF_EN
            lpf_vld <= 1'b0;
`endif
            if (bus.recal) begin
                // Also flushes any sample already registered; acc_out keeps its last value.
                state          <= ST_CAL;
                sum_q          <= '0;
                cnt_q          <= '0;
                offset_q       <= '0;
                bus.calib_done <= 1'b0;
`ifdef ACC_LPF_EN
                for (int i = 0; i < 4; i++) tap_q[i] <= '0;
`endif
            end else begin
                if (raw_vld) begin
                    case (state)
                        ST_CAL: begin
                            if (cnt_q == {CAL_LOG2{1'b1}}) begin
                                offset_q       <= offset_next;
                                sum_q          <= '0;
                                cnt_q          <= '0;
                                bus.calib_done <= 1'b1;
                                state          <= ST_RUN;
                            end else begin
                                sum_q <= sum_next;
                                cnt_q <= cnt_q + CAL_LOG2'(1);
                            end
                        end
                        ST_RUN: begin
`ifdef ACC_LPF_EN
                            tap_q[0] <= sat;
                            tap_q[1] <= tap_q[0];
                            tap_q[2] <= tap_q[1];
                            tap_q[3] <= tap_q[2];
                            lpf_vld  <= 1'b1;
`else
                            bus.acc_out   <= sat;
                            bus.acc_valid <= 1'b1;
`endif
                        end
                        default: state <= ST_CAL;
                    endcase
                end
`ifdef ACC_LPF_EN
                if (lpf_vld) begin
                    bus.acc_out   <= lpf_avg;
                    bus.acc_valid <= 1'b1;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_acc_conditioner.sv
// tb/tb_acc_conditioner.sv - scoreboard bench for acc_conditioner with CAL_LOG2=2
module tb_acc_conditioner;
    localparam int CAL_LOG2    = 2;
    localparam int SYNC_STAGES = 2;
`ifdef ACC_LPF_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic clk = 1'b0;
    logic reset;
    acc_conditioner_if bus ();

    acc_conditioner #(.CAL_LOG2(CAL_LOG2), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_strobes = 0;
    int   last_strobe = 0;
    int   prev_strobe = 0;
    int   mdl_offset = 0;
    int   hist[4];

    always @(posedge clk) cyc++;

    // Every strobe must match the oldest expectation, both in value and in cycle.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.acc_valid === 1'b1) begin
            n_strobes++;
            prev_strobe = last_strobe;
            last_strobe = cyc;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe acc_out=%h cyc=%0d", bus.acc_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.acc_out !== mon_e.val) begin
                    n_fail++;
                    $display("FAIL acc_out got=%h exp=%h cyc=%0d", bus.acc_out, mon_e.val, cyc);
                end
                n_tests++;
                if (cyc !== mon_e.due) begin
                    n_fail++;
                    $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] sat16(input int x);
        int y;
        y = x;
        if (x > 32767) y = 32767;
        if (x < -32768) y = -32768;
        return y[15:0];
    endfunction

    function automatic logic [15:0] lpf(input logic [15:0] d);
`ifdef ACC_LPF_EN
        int s;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = int'($signed(d));
        s = hist[0] + hist[1] + hist[2] + hist[3];
        s = s >>> 2;
        return s[15:0];
`else
        return d;
`endif
    endfunction

    task automatic clear_hist();
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.end_flag = 1'b0;
        bus.recal = 1'b0;
        repeat (3) @(negedge clk);
        sb.delete();
        clear_hist();
        reset = 1'b0;
    endtask

    task automatic send(input logic [15:0] v, input bit push, input logic [15:0] expv, input int hi);
        exp_t e;
        @(negedge clk);
        bus.rx_hi = v[15:8];
        bus.rx_lo = v[7:0];
        bus.end_flag = 1'b1;
        if (push) begin
            e.val = expv;
            e.due = cyc + LAT;
            sb.push_back(e);
        end
        repeat (hi - 1) @(negedge clk);
        bus.end_flag = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic calibrate(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        int s;
        send(a, 0, 16'h0, 3);
        send(b, 0, 16'h0, 3);
        send(c, 0, 16'h0, 3);
        send(d, 0, 16'h0, 3);
        s = int'($signed(a)) + int'($signed(b)) + int'($signed(c)) + int'($signed(d));
        mdl_offset = s >>> 2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.end_flag = 1'b0;
        bus.recal = 1'b0;
        bus.rx_hi = 8'h00;
        bus.rx_lo = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_hist();
        @(negedge clk);
        n_tests++;
        if (bus.acc_out !== 16'h0000) begin n_fail++; $display("FAIL reset_acc_out got=%h exp=0000", bus.acc_out); end
        n_tests++;
        if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_acc_valid got=%b exp=0", bus.acc_valid); end
        n_tests++;
        if (bus.calib_done !== 1'b0) begin n_fail++; $display("FAIL reset_calib_done got=%b exp=0", bus.calib_done); end
    endtask

    task automatic test_basic_cal();
        logic [15:0] cal_v[3] = '{16'h0010, 16'h0014, 16'h000C};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            send(cal_v[i], 0, 16'h0, 3);
            n_tests++;
            if (bus.calib_done !== 1'b0) begin n_fail++; $display("FAIL basic_cal_early sample=%0d got=%b exp=0", i, bus.calib_done); end
        end
        send(16'h0010, 0, 16'h0, 3);
        mdl_offset = 16;
        n_tests++;
        if (bus.calib_done !== 1'b1) begin n_fail++; $display("FAIL basic_cal_done got=%b exp=1", bus.calib_done); end
        send(16'h0110, 1, lpf(16'h0100), 3);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_floor();
        apply_reset();
        calibrate(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE);
        send(16'h0000, 1, lpf(16'h0002), 3);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_saturation();
        apply_reset();
        calibrate(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
        send(16'h7FF0, 1, lpf(16'h7FFF), 3);
        repeat (2) @(negedge clk);
        apply_reset();
        calibrate(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        send(16'h8000, 1, lpf(16'h8000), 3);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_held();
        int s0;
        s0 = n_strobes;
        send(16'h0500, 1, lpf(16'h0400), 50);
        repeat (4) @(negedge clk);
        n_tests++;
        if (n_strobes - s0 !== 1) begin n_fail++; $display("FAIL held_level pulses got=%0d exp=1", n_strobes - s0); end
        s0 = n_strobes;
        send(16'h0200, 1, lpf(16'h0100), 3);
        send(16'h0300, 1, lpf(16'h0200), 3);
        repeat (4) @(negedge clk);
        n_tests++;
        if (n_strobes - s0 !== 2) begin n_fail++; $display("FAIL two_edges pulses got=%0d exp=2", n_strobes - s0); end
        n_tests++;
        if (last_strobe - prev_strobe < 4) begin n_fail++; $display("FAIL two_edges gap got=%0d exp>=4", last_strobe - prev_strobe); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        exp_t e;
        apply_reset();
        calibrate(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            @(negedge clk);
            bus.rx_hi = v[15:8];
            bus.rx_lo = v[7:0];
            bus.end_flag = 1'b1;
            e.val = lpf(sat16(int'($signed(v)) - mdl_offset));
            e.due = cyc + LAT;
            sb.push_back(e);
            @(negedge clk);
            @(negedge clk);
            bus.end_flag = 1'b0;
        end
        repeat (8) @(negedge clk);
        n_tests++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL back_to_back pending got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_recal_collision();
        logic [15:0] cal_v[3] = '{16'h0040, 16'h0044, 16'h003C};
        apply_reset();
        calibrate(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        send(16'h0007, 1, lpf(16'h0007), 3);
        n_tests++;
        if (bus.calib_done !== 1'b1) begin n_fail++; $display("FAIL recal_pre calib_done got=%b exp=1", bus.calib_done); end
        @(negedge clk);
        bus.rx_hi = 8'h12;
        bus.rx_lo = 8'h34;
        bus.end_flag = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.recal = 1'b1;
        @(negedge clk);
        bus.recal = 1'b0;
        clear_hist();
        n_tests++;
        if (bus.calib_done !== 1'b0) begin n_fail++; $display("FAIL recal_calib_done got=%b exp=0", bus.calib_done); end
        @(negedge clk);
        bus.end_flag = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.acc_out !== lpf_peek()) begin n_fail++; $display("FAIL recal_hold acc_out got=%h exp=%h", bus.acc_out, lpf_peek()); end
        for (int i = 0; i < 3; i++) begin
            send(cal_v[i], 0, 16'h0, 3);
            n_tests++;
            if (bus.calib_done !== 1'b0) begin n_fail++; $display("FAIL recal_cal_early sample=%0d got=%b exp=0", i, bus.calib_done); end
        end
        send(16'h0040, 0, 16'h0, 3);
        n_tests++;
        if (bus.calib_done !== 1'b1) begin n_fail++; $display("FAIL recal_cal_done got=%b exp=1", bus.calib_done); end
        send(16'h0050, 1, lpf(16'h0010), 3);
        repeat (2) @(negedge clk);
    endtask

    // Value acc_out must still hold after the recal in test_recal_collision.
    function automatic logic [15:0] lpf_peek();
`ifdef ACC_LPF_EN
        return 16'h0001;
`else
        return 16'h0007;
`endif
    endfunction

    task automatic test_reset_mid_cal();
        @(negedge clk);
        bus.recal = 1'b1;
        @(negedge clk);
        bus.recal = 1'b0;
        clear_hist();
        send(16'h1000, 0, 16'h0, 3);
        send(16'h1000, 0, 16'h0, 3);
        @(negedge clk);
        bus.rx_hi = 8'h10;
        bus.rx_lo = 8'h00;
        bus.end_flag = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.acc_out !== 16'h0000) begin n_fail++; $display("FAIL midcal_reset_acc_out got=%h exp=0000", bus.acc_out); end
        n_tests++;
        if (bus.acc_valid !== 1'b0) begin n_fail++; $display("FAIL midcal_reset_acc_valid got=%b exp=0", bus.acc_valid); end
        n_tests++;
        if (bus.calib_done !== 1'b0) begin n_fail++; $display("FAIL midcal_reset_calib_done got=%b exp=0", bus.calib_done); end
        bus.end_flag = 1'b0;
        @(negedge clk);
        sb.delete();
        clear_hist();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(16'h0020, 0, 16'h0, 3);
            n_tests++;
            if (bus.calib_done !== 1'b0) begin n_fail++; $display("FAIL midcal_early sample=%0d got=%b exp=0", i, bus.calib_done); end
        end
        send(16'h0020, 0, 16'h0, 3);
        n_tests++;
        if (bus.calib_done !== 1'b1) begin n_fail++; $display("FAIL midcal_done got=%b exp=1", bus.calib_done); end
        send(16'h0030, 1, lpf(16'h0010), 3);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_cal();
        test_floor();
        test_saturation();
        test_held();
        test_back_to_back();
        test_recal_collision();
        test_reset_mid_cal();
        repeat (10) @(negedge clk);
        n_tests++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL final_pending got=%0d exp=0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
